controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_pkg.sv | 58 +++++
 rtl/controller_if.sv | 27 ++
 rtl/alu_decoder.sv | 30 +++
 rtl/controller.sv | 85 ++++++++
 tb/tb_controller.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/controller_pkg.sv
// Shared encodings and decode payload types for the single-cycle controller.
package controller_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned ALUC_W  = 3;

  typedef logic [OP_W-1:0]    op_t;
  typedef logic [FUNCT_W-1:0] funct_t;
  typedef logic [ALUOP_W-1:0] aluop_t;
  typedef logic [ALUC_W-1:0]  aluc_t;

  // Opcodes (inst[31:26])
  localparam op_t OP_RTYPE = 6'b000000;
  localparam op_t OP_LW    = 6'b100011;
  localparam op_t OP_SW    = 6'b101011;
  localparam op_t OP_BEQ   = 6'b000100;
  localparam op_t OP_ADDI  = 6'b001000;
  localparam op_t OP_J     = 6'b000010;

  // R-type function codes (inst[5:0])
  localparam funct_t F_ADD = 6'b100000;
  localparam funct_t F_SUB = 6'b100010;
  localparam funct_t F_AND = 6'b100100;
  localparam funct_t F_OR  = 6'b100101;
  localparam funct_t F_SLT = 6'b101010;

  // Main-decoder to ALU-decoder operation class
  localparam aluop_t ALUOP_ADD   = 2'b00;
  localparam aluop_t ALUOP_SUB   = 2'b01;
  localparam aluop_t ALUOP_FUNCT = 2'b10;
  localparam aluop_t ALUOP_NONE  = 2'b11;

  // ALU operation select
  localparam aluc_t ALUC_ADD = 3'b010;
  localparam aluc_t ALUC_SUB = 3'b110;
  localparam aluc_t ALUC_AND = 3'b000;
  localparam aluc_t ALUC_OR  = 3'b001;
  localparam aluc_t ALUC_SLT = 3'b111;

  typedef struct packed {
    logic reg_write;
    logic reg_dst;
    logic alu_src;
    logic branch;
    logic mem_write;
    logic mem_to_reg;
    logic mem_read;
    logic jump;
  } flags_t;

  typedef struct packed {
    flags_t flags;
    aluc_t  alu_control;
  } ctrl_t;

endpackage

// File: rtl/controller_if.sv
// Instruction fields in, registered control word out.
interface controller_if;
  import controller_pkg::*;

  op_t    op;
  funct_t funct;
  logic   RegWrite;
  logic   RegDst;
  logic   AluSrc;
  logic   Branch;
  logic   MemWrite;
  logic   MemtoReg;
  logic   MemRead;
  logic   Jump;
  aluc_t  ALUControl;

  modport master (
    output op, funct,
    input  RegWrite, RegDst, AluSrc, Branch, MemWrite, MemtoReg, MemRead, Jump, ALUControl
  );

  modport slave (
    input  op, funct,
    output RegWrite, RegDst, AluSrc, Branch, MemWrite, MemtoReg, MemRead, Jump, ALUControl
  );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: operation class plus funct to ALU select.
module alu_decoder
  import controller_pkg::*;
(
  input  funct_t funct,
  input  aluop_t aluop,
  output aluc_t  ALUControl
);

  // funct only matters for the R-type class; everything unlisted maps to 000
  always_comb begin
    ALUControl = ALUC_AND;
    case (aluop)
      ALUOP_ADD: ALUControl = ALUC_ADD;
      ALUOP_SUB: ALUControl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   ALUControl = ALUC_ADD;
          F_SUB:   ALUControl = ALUC_SUB;
          F_AND:   ALUControl = ALUC_AND;
          F_OR:    ALUControl = ALUC_OR;
          F_SLT:   ALUControl = ALUC_SLT;
          default: ALUControl = ALUC_AND;
        endcase
      end
      default: ALUControl = ALUC_AND;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Main decoder plus output register; one cycle from op/funct to control word.
module controller
  import controller_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  controller_if.slave  bus
);

  flags_t flags_c;
  aluop_t aluop_c;
  aluc_t  alu_ctrl_c;
  ctrl_t  ctrl_d;
  ctrl_t  ctrl_q;

  // Opcode to control flags; unknown opcodes use the NONE class so ALU select is 000
  always_comb begin
    flags_c = '0;
    aluop_c = ALUOP_NONE;
    case (bus.op)
      OP_RTYPE: begin
        flags_c.reg_write = 1'b1;
        flags_c.reg_dst   = 1'b1;
        aluop_c           = ALUOP_FUNCT;
      end
      OP_LW: begin
        flags_c.reg_write  = 1'b1;
        flags_c.alu_src    = 1'b1;
        flags_c.mem_to_reg = 1'b1;
        flags_c.mem_read   = 1'b1;
        aluop_c            = ALUOP_ADD;
      end
      OP_SW: begin
        flags_c.alu_src   = 1'b1;
        flags_c.mem_write = 1'b1;
        aluop_c           = ALUOP_ADD;
      end
      OP_BEQ: begin
        flags_c.branch = 1'b1;
        aluop_c        = ALUOP_SUB;
      end
      OP_ADDI: begin
        flags_c.reg_write = 1'b1;
        flags_c.alu_src   = 1'b1;
        aluop_c           = ALUOP_ADD;
      end
      OP_J: begin
        flags_c.jump = 1'b1;
        aluop_c      = ALUOP_ADD;
      end
      default: begin
        flags_c = '0;
        aluop_c = ALUOP_NONE;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct      (bus.funct),
    .aluop      (aluop_c),
    .ALUControl (alu_ctrl_c)
  );

  assign ctrl_d = '{flags: flags_c, alu_control: alu_ctrl_c};

  // Capture a fresh decode every cycle; reset clears the word immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.RegWrite   = ctrl_q.flags.reg_write;
  assign bus.RegDst     = ctrl_q.flags.reg_dst;
  assign bus.AluSrc     = ctrl_q.flags.alu_src;
  assign bus.Branch     = ctrl_q.flags.branch;
  assign bus.MemWrite   = ctrl_q.flags.mem_write;
  assign bus.MemtoReg   = ctrl_q.flags.mem_to_reg;
  assign bus.MemRead    = ctrl_q.flags.mem_read;
  assign bus.Jump       = ctrl_q.flags.jump;
  assign bus.ALUControl = ctrl_q.alu_control;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: expected words queued at drive, checked one edge later.
module tb_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    string      tag;
    logic [10:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;

  controller_if bus ();

  controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: {RegWrite RegDst AluSrc Branch MemWrite MemtoReg MemRead Jump, ALUControl}
  function automatic logic [10:0] model(input logic [5:0] o, input logic [5:0] f);
    logic [7:0] fl;
    logic [2:0] ac;
    fl = 8'b0000_0000;
    ac = 3'b000;
    if (o == 6'b000000) begin
      fl = 8'b1100_0000;
      if      (f == 6'b100000) ac = 3'b010;
      else if (f == 6'b100010) ac = 3'b110;
      else if (f == 6'b100100) ac = 3'b000;
      else if (f == 6'b100101) ac = 3'b001;
      else if (f == 6'b101010) ac = 3'b111;
      else                     ac = 3'b000;
    end else if (o == 6'b100011) begin
      fl = 8'b1010_0110; ac = 3'b010;
    end else if (o == 6'b101011) begin
      fl = 8'b0010_1000; ac = 3'b010;
    end else if (o == 6'b000100) begin
      fl = 8'b0001_0000; ac = 3'b110;
    end else if (o == 6'b001000) begin
      fl = 8'b1010_0000; ac = 3'b010;
    end else if (o == 6'b000010) begin
      fl = 8'b0000_0001; ac = 3'b010;
    end
    return {fl, ac};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.RegWrite, bus.RegDst, bus.AluSrc, bus.Branch, bus.MemWrite,
            bus.MemtoReg, bus.MemRead, bus.Jump, bus.ALUControl};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive one instruction at the falling edge and queue its expected decode
  task automatic send(input string tag, input logic [5:0] o, input logic [5:0] f);
    sb_entry_t e;
    @(negedge clk);
    bus.op    = o;
    bus.funct = f;
    e.tag = tag;
    e.exp = model(o, f);
    sb.push_back(e);
  endtask

  // Monitor: each rising edge retires the oldest queued decode
  always @(posedge clk) begin
    #1;
    if (rst && sb.size() != 0) begin
      mon_e = sb.pop_front();
      check(mon_e.tag, obs(), mon_e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sb_entry_t e;
    logic [5:0] ro;
    logic [5:0] rf;
    checks = 0;
    errors = 0;

    // Reset held with clock running
    rst       = 1'b0;
    bus.op    = 6'b000000;
    bus.funct = 6'b100000;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", obs(), 11'b0);

    // Release; first edge captures the R-type add decode
    @(negedge clk);
    rst = 1'b1;
    e.tag = "post_reset";
    e.exp = 11'b1100_0000_010;
    sb.push_back(e);

    // R-type sweep and funct corner cases
    send("r_add",  6'b000000, 6'b100000);
    send("r_sub",  6'b000000, 6'b100010);
    send("r_and",  6'b000000, 6'b100100);
    send("r_or",   6'b000000, 6'b100101);
    send("r_slt",  6'b000000, 6'b101010);
    send("r_f00",  6'b000000, 6'b000000);
    send("r_f3f",  6'b000000, 6'b111111);

    // Memory, immediate and control-flow ops, funct ignored
    send("lw",     6'b100011, 6'b000000);
    send("lw_f",   6'b100011, 6'b100010);
    send("sw",     6'b101011, 6'b101010);
    send("beq",    6'b000100, 6'b100000);
    send("addi",   6'b001000, 6'b100101);
    send("j",      6'b000010, 6'b100100);

    // Illegal opcodes
    send("ill_3f", 6'b111111, 6'b100000);
    send("ill_3f2",6'b111111, 6'b000000);
    send("ill_01", 6'b000001, 6'b100010);

    // Random opcodes across the whole space
    for (int i = 0; i < 40; i++) begin
      ro = 6'($urandom_range(0, 63));
      if (i % 3 == 0) ro = 6'($urandom_range(0, 5)) == 6'd0 ? 6'b000100 : 6'b000000;
      rf = 6'($urandom_range(0, 63));
      if (i % 4 == 0) rf = 6'b100000 | 6'($urandom_range(0, 10));
      send("rand", ro, rf);
    end

    // Async reset just after an edge that captured lw
    send("lw_pre_rst", 6'b100011, 6'b000000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    #1 check("async_rst", obs(), 11'b0);
    @(posedge clk);
    #1 check("rst_hold_edge", obs(), 11'b0);

    // In-flight decode discarded when reset lands between edges
    @(negedge clk);
    rst = 1'b1;
    bus.op    = 6'b101011;
    bus.funct = 6'b000000;
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("inflight_drop", obs(), 11'b0);

    // Recover and decode again
    @(negedge clk);
    rst = 1'b1;
    bus.op    = 6'b000100;
    bus.funct = 6'b000000;
    e.tag = "recover_beq";
    e.exp = 11'b0001_0000_110;
    sb.push_back(e);
    send("recover_j", 6'b000010, 6'b000000);

    repeat (3) @(posedge clk);
    #2 check("drain", 11'(sb.size()), 11'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
